// File: rtl/seg7_pkg.sv
// seg7_pkg: shared glyph constants and the nibble-to-segment decode helper
// for the 7-segment scan driver.
//   Glyph constants are lit-high, bit order {g,f,e,d,c,b,a}.
//   seg7_decode(nibble, hex_en): codes 0-9 give digits; 10-15 give hex
//   letters when hex_en=1, otherwise a dash.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h27;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_A    = 7'h77;
    localparam logic [6:0] SEG_B    = 7'h7C;
    localparam logic [6:0] SEG_C    = 7'h39;
    localparam logic [6:0] SEG_D    = 7'h5E;
    localparam logic [6:0] SEG_E    = 7'h79;
    localparam logic [6:0] SEG_F    = 7'h71;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble, input logic hex_en);
        logic [6:0] glyph;
        case (nibble)
            4'h0:    glyph = SEG_0;
            4'h1:    glyph = SEG_1;
            4'h2:    glyph = SEG_2;
            4'h3:    glyph = SEG_3;
            4'h4:    glyph = SEG_4;
            4'h5:    glyph = SEG_5;
            4'h6:    glyph = SEG_6;
            4'h7:    glyph = SEG_7;
            4'h8:    glyph = SEG_8;
            4'h9:    glyph = SEG_9;
            4'hA:    glyph = hex_en ? SEG_A : SEG_DASH;
            4'hB:    glyph = hex_en ? SEG_B : SEG_DASH;
            4'hC:    glyph = hex_en ? SEG_C : SEG_DASH;
            4'hD:    glyph = hex_en ? SEG_D : SEG_DASH;
            4'hE:    glyph = hex_en ? SEG_E : SEG_DASH;
            4'hF:    glyph = hex_en ? SEG_F : SEG_DASH;
            default: glyph = SEG_DASH;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// seg7_glyph_rom: combinational nibble -> lit-high segment pattern.
//   nibble  in   4  code to display
//   glyph   out  7  {g,f,e,d,c,b,a}, 1 = segment lit
module seg7_glyph_rom
    import seg7_pkg::*;
#(
    parameter bit HEX_EN = 1'b0
) (
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    // Pure table lookup through the shared decode helper.
    always_comb begin
        glyph = seg7_decode(nibble, HEX_EN);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit common-anode 7-segment driver.
//   clk, rst_n        clock, asynchronous active-low reset
//   upd_valid/ready   handshake for a new display word (bcd_in + dp_in)
//   bcd_in            nibble i drives digit i, digit 0 rightmost
//   dp_in             decimal point per digit, 1 = lit
//   lz_blank          live leading-zero suppression enable
//   seg_n, dp_n       active-low segments {g..a} and decimal point
//   dig_n             active-low digit enables, at most one low
// A new word waits in a pending buffer and is copied to the active buffer
// only at a frame end, so a frame never shows a mix of two words.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    parameter int HEX_EN    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [4*N_DIGITS-1:0]   bcd_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    lz_blank,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [N_DIGITS-1:0]     dig_n
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]    BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0]    IDX_MAX   = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] DIG_ONE   = N_DIGITS'(1);

    if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_n_digits
        $error("seg7_scan_driver: N_DIGITS must be in 1..8");
    end
    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("seg7_scan_driver: SCAN_DIV must be >= 2");
    end
    if (BLANK_CYC < 0 || BLANK_CYC >= SCAN_DIV) begin : g_bad_blank_cyc
        $error("seg7_scan_driver: BLANK_CYC must be < SCAN_DIV");
    end

    logic [CNT_W-1:0]      cnt_r;
    logic [IDX_W-1:0]      idx_r;
    logic [4*N_DIGITS-1:0] pend_bcd_r;
    logic [N_DIGITS-1:0]   pend_dp_r;
    logic                  pending_full_r;
    logic [4*N_DIGITS-1:0] act_bcd_r;
    logic [N_DIGITS-1:0]   act_dp_r;
    logic [6:0]            seg_n_r;
    logic                  dp_n_r;
    logic [N_DIGITS-1:0]   dig_n_r;

    logic                  frame_end_s;
    logic                  xfer_s;
    logic [3:0]            cur_nib_s;
    logic [6:0]            cur_glyph_s;
    logic [N_DIGITS-1:0]   lead_zero_s;
    logic                  zero_run_s;

    assign frame_end_s = (idx_r == IDX_MAX) && (cnt_r == CNT_MAX);
    // Ready is simply "pending buffer empty", so it is already a register.
    assign xfer_s      = upd_valid && !pending_full_r;
    assign upd_ready   = !pending_full_r;
    assign cur_nib_s   = act_bcd_r[{idx_r, 2'b00} +: 4];

    // Prescaler counts a digit slot; digit index advances when it wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            idx_r <= '0;
        end else if (cnt_r == CNT_MAX) begin
            cnt_r <= '0;
            idx_r <= (idx_r == IDX_MAX) ? '0 : idx_r + 1'b1;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    // Pending/active word buffers; promotion only at frame end.
    // A transfer and a promotion can never coincide because a transfer
    // needs an empty pending buffer and a promotion needs a full one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_bcd_r     <= '0;
            pend_dp_r      <= '0;
            pending_full_r <= 1'b0;
            act_bcd_r      <= '0;
            act_dp_r       <= '0;
        end else if (xfer_s) begin
            pend_bcd_r     <= bcd_in;
            pend_dp_r      <= dp_in;
            pending_full_r <= 1'b1;
        end else if (frame_end_s && pending_full_r) begin
            act_bcd_r      <= pend_bcd_r;
            act_dp_r       <= pend_dp_r;
            pending_full_r <= 1'b0;
        end
    end

    // Walk from the most significant digit down; a digit is a leading zero
    // while every nibble above and including it is zero. Digit 0 is exempt.
    always_comb begin
        lead_zero_s = '0;
        zero_run_s  = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_run_s     = zero_run_s & (act_bcd_r[4*k +: 4] == 4'h0);
            lead_zero_s[k] = zero_run_s & lz_blank & (k != 0);
        end
    end

    seg7_glyph_rom #(
        .HEX_EN (HEX_EN != 0)
    ) u_glyph_rom (
        .nibble (cur_nib_s),
        .glyph  (cur_glyph_s)
    );

    // Output registers: anti-ghost blanking at slot start, else drive the digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n_r <= 7'h7F;
            dp_n_r  <= 1'b1;
            dig_n_r <= '1;
        end else if (cnt_r < BLANK_END) begin
            seg_n_r <= 7'h7F;
            dp_n_r  <= 1'b1;
            dig_n_r <= '1;
        end else begin
            seg_n_r <= lead_zero_s[idx_r] ? ~SEG_OFF : ~cur_glyph_s;
            dp_n_r  <= ~act_dp_r[idx_r];
            dig_n_r <= ~(DIG_ONE << idx_r);
        end
    end

    assign seg_n = seg_n_r;
    assign dp_n  = dp_n_r;
    assign dig_n = dig_n_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench: two drivers (HEX_EN=0 and HEX_EN=1) share all inputs.
// A cycle-level reference model computes every output from elapsed time and
// the words handed over; literal checks pin the glyph table and timing.
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = N * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        upd_valid = 1'b0;
    logic        lz_blank = 1'b0;
    logic [15:0] bcd_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;

    logic        rdy0, rdy1, dpn0, dpn1;
    logic [6:0]  seg0, seg1;
    logic [3:0]  dig0, dig1;

    seg7_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(BC), .HEX_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(rdy0),
        .bcd_in(bcd_in), .dp_in(dp_in), .lz_blank(lz_blank),
        .seg_n(seg0), .dp_n(dpn0), .dig_n(dig0));

    seg7_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(BC), .HEX_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(rdy1),
        .bcd_in(bcd_in), .dp_in(dp_in), .lz_blank(lz_blank),
        .seg_n(seg1), .dp_n(dpn1), .dig_n(dig1));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [6:0] ref_lit(input int code, input bit hex);
        if (code >= 10 && !hex) return 7'h40;
        case (code)
            0: return 7'h3F;   1: return 7'h06;   2: return 7'h5B;   3: return 7'h4F;
            4: return 7'h66;   5: return 7'h6D;   6: return 7'h7D;   7: return 7'h27;
            8: return 7'h7F;   9: return 7'h6F;  10: return 7'h77;  11: return 7'h7C;
            12: return 7'h39; 13: return 7'h5E;  14: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int t, input logic [15:0] w, input bit lz, input bit hex);
        int slot = t % SD;
        int dig  = (t / SD) % N;
        if (slot < BC) return 7'h7F;
        if (lz && dig != 0 && (w >> (4*dig)) == 16'h0) return 7'h7F;
        return ~ref_lit(int'((w >> (4*dig)) & 16'hF), hex);
    endfunction

    function automatic logic [3:0] exp_dig(input int t);
        if ((t % SD) < BC) return 4'hF;
        return 4'hF ^ (4'h1 << ((t / SD) % N));
    endfunction

    function automatic logic exp_dpn(input int t, input logic [3:0] d);
        if ((t % SD) < BC) return 1'b1;
        return ~d[(t / SD) % N];
    endfunction

    int          m_ticks;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_act_dp, m_pend_dp;
    bit          m_pf;
    logic [6:0]  e_seg0, e_seg1;
    logic        e_dpn, e_rdy;
    logic [3:0]  e_dig;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ticks <= 0;   m_act <= 16'h0; m_pend <= 16'h0;
            m_act_dp <= 4'h0; m_pend_dp <= 4'h0; m_pf <= 1'b0;
            e_seg0 <= 7'h7F; e_seg1 <= 7'h7F; e_dpn <= 1'b1; e_dig <= 4'hF; e_rdy <= 1'b1;
        end else begin
            e_seg0 <= exp_seg(m_ticks, m_act, lz_blank, 1'b0);
            e_seg1 <= exp_seg(m_ticks, m_act, lz_blank, 1'b1);
            e_dig  <= exp_dig(m_ticks);
            e_dpn  <= exp_dpn(m_ticks, m_act_dp);
            if (upd_valid && !m_pf) begin
                m_pend <= bcd_in; m_pend_dp <= dp_in; m_pf <= 1'b1; e_rdy <= 1'b0;
            end else if ((m_ticks % FRAME) == FRAME - 1 && m_pf) begin
                m_act <= m_pend; m_act_dp <= m_pend_dp; m_pf <= 1'b0; e_rdy <= 1'b1;
            end else begin
                e_rdy <= !m_pf;
            end
            m_ticks <= m_ticks + 1;
        end
    end

    // Cycle-by-cycle comparison away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("seg_n_dec", 32'(seg0), 32'(e_seg0));
            chk("seg_n_hex", 32'(seg1), 32'(e_seg1));
            chk("dp_n_dec",  32'(dpn0), 32'(e_dpn));
            chk("dp_n_hex",  32'(dpn1), 32'(e_dpn));
            chk("dig_n_dec", 32'(dig0), 32'(e_dig));
            chk("dig_n_hex", 32'(dig1), 32'(e_dig));
            chk("ready_dec", 32'(rdy0), 32'(e_rdy));
            chk("ready_hex", 32'(rdy1), 32'(e_rdy));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [15:0] w, input logic [3:0] d);
        bit done = 1'b0;
        @(negedge clk);
        bcd_in = w; dp_in = d; upd_valid = 1'b1;
        for (int i = 0; i < 4*FRAME && !done; i++) begin
            if (rdy0) done = 1'b1;
            @(negedge clk);
        end
        upd_valid = 1'b0;
        if (!done) begin
            n_vec++; n_bad++;
            $display("FAIL send_timeout: word %0h not accepted within %0d cycles", w, 4*FRAME);
        end
    endtask

    task automatic wait_digit(input int k);
        bit ok = 1'b0;
        for (int i = 0; i < 2*FRAME && !ok; i++) begin
            @(negedge clk);
            if (dig0 == (4'hF ^ (4'h1 << k))) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++; n_bad++;
            $display("FAIL wait_digit%0d: digit never lit within %0d cycles", k, 2*FRAME);
        end
    endtask

    initial begin
        int lit_cnt;
        int low_cnt;
        logic [15:0] w;

        // Reset release: blank for BLANK_CYC cycles, then digit 0 shows "0".
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_blank_dig", 32'(dig0), 32'h0000000F);
        @(negedge clk);
        chk("first_lit_dig", 32'(dig0), 32'h0000000E);
        chk("first_lit_seg", 32'(seg0), 32'h00000040);

        // 16'h1234: digit i shows nibble i.
        send(16'h1234, 4'h0);
        repeat (2*FRAME) @(negedge clk);
        wait_digit(0); chk("w1234_d0", 32'(seg0), 32'h19);
        wait_digit(1); chk("w1234_d1", 32'(seg0), 32'h30);
        wait_digit(2); chk("w1234_d2", 32'(seg0), 32'h24);
        wait_digit(3); chk("w1234_d3", 32'(seg0), 32'h79);
        lit_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (dig0[0] == 1'b0) lit_cnt++;
        end
        chk("digit0_lit_cycles", 32'(lit_cnt), 32'(SD - BC));

        // Leading-zero suppression, dash vs hex glyph.
        lz_blank = 1'b1;
        send(16'h00A7, 4'h0);
        repeat (2*FRAME) @(negedge clk);
        wait_digit(3); chk("w00A7_d3_dec", 32'(seg0), 32'h7F); chk("w00A7_d3_hex", 32'(seg1), 32'h7F);
        wait_digit(2); chk("w00A7_d2_dec", 32'(seg0), 32'h7F);
        wait_digit(1); chk("w00A7_d1_dash", 32'(seg0), 32'h3F); chk("w00A7_d1_hexA", 32'(seg1), 32'h08);
        wait_digit(0); chk("w00A7_d0", 32'(seg0), 32'h58);

        // All zeros with a decimal point on digit 2.
        send(16'h0000, 4'b0100);
        repeat (2*FRAME) @(negedge clk);
        wait_digit(3); chk("w0000_d3_seg", 32'(seg0), 32'h7F); chk("w0000_d3_dp", 32'(dpn0), 32'h1);
        wait_digit(2); chk("w0000_d2_seg", 32'(seg0), 32'h7F); chk("w0000_d2_dp", 32'(dpn0), 32'h0);
        wait_digit(1); chk("w0000_d1_seg", 32'(seg0), 32'h7F);
        wait_digit(0); chk("w0000_d0_seg", 32'(seg0), 32'h40); chk("w0000_d0_dp", 32'(dpn0), 32'h1);
        lz_blank = 1'b0;

        // Back-to-back words: B is held until A has been applied.
        send(16'h9876, 4'h1);
        send(16'h4321, 4'h8);
        repeat (2*FRAME) @(negedge clk);

        // Word offered exactly on the frame-end cycle: ready stays low one frame.
        for (int i = 0; i < 2*FRAME && !((m_ticks % FRAME) == FRAME - 1 && rdy0); i++) @(negedge clk);
        bcd_in = 16'h5678; dp_in = 4'h2; upd_valid = 1'b1;
        @(negedge clk);
        upd_valid = 1'b0;
        low_cnt = 0;
        for (int i = 0; i < 2*FRAME && !rdy0; i++) begin
            low_cnt++;
            @(negedge clk);
        end
        chk("frame_end_ready_low", 32'(low_cnt), 32'(FRAME));
        repeat (FRAME) @(negedge clk);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            w = 16'($urandom) >> (4 * $urandom_range(0, 4));
            bcd_in    = w;
            dp_in     = 4'($urandom);
            upd_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) lz_blank = ~lz_blank;
        end
        upd_valid = 1'b0;

        // Asynchronous reset mid-scan, away from any clock edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_seg",   32'(seg0), 32'h7F);
        chk("async_rst_dp",    32'(dpn0), 32'h1);
        chk("async_rst_dig",   32'(dig0), 32'hF);
        chk("async_rst_ready", 32'(rdy0), 32'h1);
        chk("async_rst_seg_hex", 32'(seg1), 32'h7F);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rerelease_dig", 32'(dig0), 32'hE);
        chk("rerelease_seg", 32'(seg0), 32'h40);
        repeat (FRAME) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
